banked_mem_ctrl: RTL and testbench
==================================

Name: banked_mem_ctrl

Overview:
Multi-port, multi-bank on-chip memory backend for the AXI-to-memory request interface (req/gnt/addr/we/strb/wdata -> rvalid/rdata). Requests are word-interleaved across NUM_BANKS single-port byte-writable banks. Per-bank round-robin arbitration resolves port conflicts. Responses return at a fixed, parametrised READ_LATENCY. Sits between the protocol converters and block RAM, so one memory can serve both instruction and data AXI slaves.

Parameters:
NUM_PORTS, 2, number of independent request ports (1..4)
NUM_BANKS, 2, number of interleaved banks, power of two (1..8)
ADDR_WIDTH, 32, byte address width per port
DATA_WIDTH, 32, word width in bits, multiple of 8
BANK_WORDS, 32768, words per bank, power of two
READ_LATENCY, 2, cycles from grant to rvalid (1..4)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_i  in  NUM_PORTS  request valid per port
gnt_o  out  NUM_PORTS  request accepted this cycle
addr_i  in  NUM_PORTS*ADDR_WIDTH  byte address per port
we_i  in  NUM_PORTS  1 = write, 0 = read
strb_i  in  NUM_PORTS*DATA_WIDTH/8  byte enables for writes
wdata_i  in  NUM_PORTS*DATA_WIDTH  write data
rvalid_o  out  NUM_PORTS  response valid
rdata_o  out  NUM_PORTS*DATA_WIDTH  read data; 0 for writes and errors
err_o  out  NUM_PORTS  response error flag, qualified by rvalid_o

Behaviour:
- Address decode: OFF = log2(DATA_WIDTH/8) bits ignored. Bank = addr[OFF +: log2(NUM_BANKS)]. Row = next log2(BANK_WORDS) bits. Any set bit above row: out-of-range.
- Arbitration: per bank, combinational. Among ports with req_i and decoding to that bank, grant the first at or after rr_ptr[bank], scanning upward with wrap. After a grant, rr_ptr[bank] = winner+1 (mod NUM_PORTS). At most one grant per bank per cycle. Ports on different banks are granted in parallel.
- Out-of-range requests: always granted the same cycle and never enter bank arbitration. No memory access. Response after READ_LATENCY with err_o=1 and rdata=0.
- gnt_o depends combinationally on req_i/addr_i. Requesters hold request fields until granted. Ungranted requests cause no side effects.
- Write: on the grant edge, bytes with strb=1 are written to bank[row]. strb=0 is legal: no bytes change, response still returned. Write responses return rvalid_o=1, rdata=0, err=0.
- Read: bank output registered (1 cycle). READ_LATENCY-1 further output register stages follow.
- Response pipeline per port: shift register of {valid, is_read, err, bank} of depth READ_LATENCY. rvalid_o is asserted exactly READ_LATENCY cycles after the gnt_o cycle. rdata_o is muxed from the tagged bank's delayed output.
- Throughput: one request per port per cycle when there are no conflicts. No backpressure on responses.
- Reset (async assert, sync deassert by the integrator): rvalid_o=0, err_o=0, rdata_o=0, all rr_ptr=0, response pipeline cleared. In-flight responses are dropped. Memory contents are preserved.
- gnt_o is 0 while rst_ni=0.

Test Plan:
- Single read, latency 2: write port0 addr 0x10 data 0xDEADBEEF strb 0xF, then read 0x10. rvalid_o[0] rises exactly 2 cycles after gnt with rdata 0xDEADBEEF, err 0. Repeat with READ_LATENCY=1 and 4.
- Bank conflict: port0 and port1 both read bank 0 (0x00, 0x08) every cycle for 4 cycles, holding until granted. Grants alternate 0,1,0,1, starting with port0 after reset. No response is lost or duplicated.
- Parallel banks: port0 reads 0x00 (bank0) and port1 reads 0x04 (bank1) in the same cycle. Both are granted that cycle. Both rvalid_o assert together, with correct data.
- Byte strobes: write 0x11223344 strb 0xF, then 0xAABBCCDD strb 0x5, then read. rdata = 0x11BB33DD. The write response has rvalid=1 and rdata=0.
- Out of range: read addr 0x0004_0000 with 2 banks, 32768 words and 32-bit data. Granted immediately; after READ_LATENCY cycles err_o=1, rdata=0. Memory is unchanged.
- Reset mid-flight: assert rst_ni=0 one cycle after a read grant. rvalid_o stays 0 and no stale response appears after release. A subsequent read of previously written data still returns it.

Source files
------------

// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl
//   Multi-port, word-interleaved, multi-bank on-chip memory backend. Each port
//   issues req/addr/we/strb/wdata and receives rvalid/rdata/err a fixed
//   READ_LATENCY cycles after its grant. Every bank has its own round-robin
//   arbiter, so ports that target different banks proceed in parallel.
//
// Ports
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   req_i / gnt_o      per-port request valid / accepted this cycle
//   addr_i             per-port byte address
//   we_i, strb_i       per-port write enable and byte enables
//   wdata_i            per-port write data
//   rvalid_o, err_o    per-port response valid and error flag
//   rdata_o            per-port read data (0 for writes and errors)
module banked_mem_ctrl #(
    parameter int NUM_PORTS    = 2,
    parameter int NUM_BANKS    = 2,
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int BANK_WORDS   = 32768,
    parameter int READ_LATENCY = 2
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NUM_PORTS-1:0]              req_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] strb_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o,
    output logic [NUM_PORTS-1:0]              err_o
);

    localparam int NB        = DATA_WIDTH / 8;
    localparam int OFF       = $clog2(NB);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BW        = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_BITS  = $clog2(BANK_WORDS);
    localparam int TOP       = OFF + BANK_BITS + ROW_BITS;
    localparam int PW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef struct packed {
        logic          valid;
        logic          is_read;
        logic          err;
        logic [BW-1:0] bank;
    } resp_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [BW-1:0]       bank_sel [NUM_PORTS];
    logic [ROW_BITS-1:0] row      [NUM_PORTS];
    logic [NUM_PORTS-1:0] oor;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
        logic [ADDR_WIDTH-1:0] a;
        assign a = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];

        if (BANK_BITS > 0) begin : g_bsel
            assign bank_sel[p] = a[OFF +: BANK_BITS];
        end else begin : g_bsel0
            assign bank_sel[p] = '0;
        end

        assign row[p] = a[OFF+BANK_BITS +: ROW_BITS];

        if (TOP < ADDR_WIDTH) begin : g_oor
            assign oor[p] = |a[ADDR_WIDTH-1:TOP];
        end else begin : g_no_oor
            assign oor[p] = 1'b0;
        end

        // Byte-offset bits only select within a word and are not decoded.
        if (OFF > 0) begin : g_lsb
            logic unused_lsb;
            assign unused_lsb = ^a[OFF-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Per-bank round-robin arbitration
    // ------------------------------------------------------------------
    logic [PW-1:0]        rr_q   [NUM_BANKS];
    logic [PW-1:0]        rr_d   [NUM_BANKS];
    logic [PW-1:0]        bk_win [NUM_BANKS];
    logic [NUM_BANKS-1:0] bk_vld;
    logic [NUM_BANKS-1:0] acc_en;
    logic [NUM_PORTS-1:0] gnt;

    always_comb begin
        int p;
        p   = 0;
        // Out-of-range requests bypass the banks and are always accepted.
        gnt = req_i & oor;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bk_vld[b] = 1'b0;
            bk_win[b] = '0;
            rr_d[b]   = rr_q[b];
            // Scan from the far end so the closest match to rr_q wins.
            for (int k = NUM_PORTS - 1; k >= 0; k--) begin
                p = int'(rr_q[b]) + k;
                if (p >= NUM_PORTS) p = p - NUM_PORTS;
                if (req_i[p] && !oor[p] && (int'(bank_sel[p]) == b)) begin
                    bk_vld[b] = 1'b1;
                    bk_win[b] = PW'(p);
                end
            end
            if (bk_vld[b]) begin
                gnt[bk_win[b]] = 1'b1;
                rr_d[b] = (int'(bk_win[b]) == NUM_PORTS - 1) ? '0 : bk_win[b] + 1'b1;
            end
        end
    end

    assign gnt_o  = rst_ni ? gnt : '0;
    assign acc_en = rst_ni ? bk_vld : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int b = 0; b < NUM_BANKS; b++) rr_q[b] <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end

    // ------------------------------------------------------------------
    // Banks: byte-writable storage plus a read data delay line
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] bank_out [NUM_BANKS];

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem_q [BANK_WORDS];
        logic [DATA_WIDTH-1:0] dly_q [READ_LATENCY];
        logic [PW-1:0]         w;
        logic [ROW_BITS-1:0]   r;
        logic                  wr;
        logic [NB-1:0]         s;
        logic [DATA_WIDTH-1:0] wd;

        assign w  = bk_win[b];
        assign r  = row[w];
        assign wr = we_i[w];
        assign s  = strb_i[int'(w)*NB +: NB];
        assign wd = wdata_i[int'(w)*DATA_WIDTH +: DATA_WIDTH];

        // Storage has no reset so contents survive a controller reset.
        always_ff @(posedge clk_i) begin
            if (acc_en[b] && wr) begin
                for (int i = 0; i < NB; i++) begin
                    if (s[i]) mem_q[r][i*8 +: 8] <= wd[i*8 +: 8];
                end
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < READ_LATENCY; i++) dly_q[i] <= '0;
            end else begin
                if (acc_en[b] && !wr) dly_q[0] <= mem_q[r];
                for (int i = 1; i < READ_LATENCY; i++) dly_q[i] <= dly_q[i-1];
            end
        end

        assign bank_out[b] = dly_q[READ_LATENCY-1];
    end

    // ------------------------------------------------------------------
    // Response pipeline, one tag shift register per port
    // ------------------------------------------------------------------
    resp_t pipe_q [NUM_PORTS][READ_LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int i = 0; i < READ_LATENCY; i++) pipe_q[p][i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                pipe_q[p][0].valid   <= gnt[p];
                pipe_q[p][0].is_read <= ~we_i[p] & ~oor[p];
                pipe_q[p][0].err     <= oor[p];
                pipe_q[p][0].bank    <= bank_sel[p];
                for (int i = 1; i < READ_LATENCY; i++) pipe_q[p][i] <= pipe_q[p][i-1];
            end
        end
    end

    always_comb begin
        rvalid_o = '0;
        err_o    = '0;
        rdata_o  = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            rvalid_o[p] = pipe_q[p][READ_LATENCY-1].valid;
            err_o[p]    = pipe_q[p][READ_LATENCY-1].valid & pipe_q[p][READ_LATENCY-1].err;
            if (pipe_q[p][READ_LATENCY-1].valid && pipe_q[p][READ_LATENCY-1].is_read) begin
                rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = bank_out[pipe_q[p][READ_LATENCY-1].bank];
            end
        end
    end

endmodule

// File: tb/tb_banked_mem_ctrl.sv
module tb_banked_mem_ctrl;

    localparam int NP  = 2;
    localparam int LAT = 2;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [1:0]    req_i = '0;
    logic [1:0]    gnt_o;
    logic [63:0]   addr_i = '0;
    logic [1:0]    we_i = '0;
    logic [7:0]    strb_i = '0;
    logic [63:0]   wdata_i = '0;
    logic [1:0]    rvalid_o;
    logic [63:0]   rdata_o;
    logic [1:0]    err_o;

    banked_mem_ctrl #(
        .NUM_PORTS(2), .NUM_BANKS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .BANK_WORDS(32768), .READ_LATENCY(LAT)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .addr_i(addr_i), .we_i(we_i), .strb_i(strb_i), .wdata_i(wdata_i),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
    } exp_t;

    exp_t sb_q [NP][$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is presented.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int p = 0; p < NP; p++) begin
                if (rvalid_o[p]) begin
                    if (sb_q[p].size() == 0) begin
                        chk(1'b0, $sformatf("spurious_rvalid_p%0d", p), 32'(rvalid_o[p]), 32'd0);
                    end else begin
                        mon_e = sb_q[p].pop_front();
                        chk(rdata_o[p*32 +: 32] === mon_e.data, $sformatf("rdata_p%0d", p),
                            rdata_o[p*32 +: 32], mon_e.data);
                        chk(err_o[p] === mon_e.err, $sformatf("err_p%0d", p),
                            32'(err_o[p]), 32'(mon_e.err));
                        chk(cyc == mon_e.due, $sformatf("latency_p%0d", p), 32'(cyc), 32'(mon_e.due));
                    end
                end else if (sb_q[p].size() != 0 && sb_q[p][0].due <= cyc) begin
                    mon_e = sb_q[p].pop_front();
                    chk(1'b0, $sformatf("missing_rvalid_p%0d", p), 32'(cyc), 32'(mon_e.due));
                end
            end
        end
    end

    task automatic push(input int p, input logic [31:0] d, input logic e);
        exp_t x;
        x.data = d;
        x.err  = e;
        x.due  = cyc + LAT;
        sb_q[p].push_back(x);
    endtask

    // One request cycle: drive, check the grant, queue expected responses.
    task automatic op(input logic [1:0] req, input logic [1:0] we,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [3:0] s0, input logic [3:0] s1,
                      input logic [1:0] exp_gnt,
                      input logic [31:0] r0, input logic [31:0] r1,
                      input logic [1:0] e_err, input string name);
        @(posedge clk_i); #1;
        req_i   = req;
        we_i    = we;
        addr_i  = {a1, a0};
        wdata_i = {d1, d0};
        strb_i  = {s1, s0};
        @(negedge clk_i);
        chk(gnt_o === exp_gnt, {"gnt_", name}, 32'(gnt_o), 32'(exp_gnt));
        if (gnt_o[0]) push(0, r0, e_err[0]);
        if (gnt_o[1]) push(1, r1, e_err[1]);
    endtask

    task automatic idle(input int n);
        @(posedge clk_i); #1;
        req_i = '0;
        we_i  = '0;
        strb_i = '0;
        repeat (n - 1) @(posedge clk_i);
    endtask

    localparam logic [31:0] V00 = 32'h0A0A_0000;
    localparam logic [31:0] V08 = 32'h0808_1111;
    localparam logic [31:0] V04 = 32'h0404_2222;
    localparam logic [31:0] V10 = 32'hDEAD_BEEF;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int rem0, rem1, k;
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

        // Reset state, with requests pending
        req_i = 2'b11;
        addr_i = {32'h4, 32'h0};
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk(gnt_o === 2'b00, "reset_gnt", 32'(gnt_o), 32'd0);
        chk(rvalid_o === 2'b00, "reset_rvalid", 32'(rvalid_o), 32'd0);
        chk(err_o === 2'b00, "reset_err", 32'(err_o), 32'd0);
        chk(rdata_o === 64'd0, "reset_rdata", rdata_o[31:0] | rdata_o[63:32], 32'd0);
        @(posedge clk_i); #1;
        req_i = '0;
        rst_ni = 1'b1;

        // Preload through port 0; write responses carry zero data
        op(2'b01, 2'b01, 32'h00, 0, V00, 0, 4'hF, 0, 2'b01, 0, 0, 2'b00, "wr00");
        op(2'b01, 2'b01, 32'h08, 0, V08, 0, 4'hF, 0, 2'b01, 0, 0, 2'b00, "wr08");
        op(2'b01, 2'b01, 32'h04, 0, V04, 0, 4'hF, 0, 2'b01, 0, 0, 2'b00, "wr04");
        op(2'b01, 2'b01, 32'h10, 0, V10, 0, 4'hF, 0, 2'b01, 0, 0, 2'b00, "wr10");
        op(2'b01, 2'b00, 32'h10, 0, 0, 0, 0, 0, 2'b01, V10, 0, 2'b00, "rd10_p0");
        op(2'b10, 2'b00, 0, 32'h10, 0, 0, 0, 0, 2'b10, 0, V10, 2'b00, "rd10_p1");
        idle(LAT + 2);

        // Reset one cycle after a read grant: in-flight response dropped
        op(2'b01, 2'b00, 32'h08, 0, 0, 0, 0, 0, 2'b01, V08, 0, 2'b00, "rd08_pre_rst");
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        sb_q[0].delete();
        sb_q[1].delete();
        repeat (LAT + 1) begin
            @(negedge clk_i);
            chk(rvalid_o === 2'b00, "rst_rvalid", 32'(rvalid_o), 32'd0);
            chk(gnt_o === 2'b00, "rst_gnt", 32'(gnt_o), 32'd0);
        end
        @(posedge clk_i); #1;
        req_i = '0;
        rst_ni = 1'b1;
        idle(LAT + 3);

        // Bank 0 conflict: pointer reset to port 0, grants alternate
        rem0 = 2; rem1 = 2; k = 0;
        while ((rem0 > 0 || rem1 > 0) && k < 10) begin
            @(posedge clk_i); #1;
            req_i  = {rem1 > 0, rem0 > 0};
            we_i   = '0;
            addr_i = {32'h08, 32'h00};
            @(negedge clk_i);
            if (k < 4) chk(gnt_o === exp_seq[k], $sformatf("gnt_conflict_%0d", k), 32'(gnt_o), 32'(exp_seq[k]));
            if (gnt_o[0]) begin push(0, V00, 1'b0); rem0--; end
            if (gnt_o[1]) begin push(1, V08, 1'b0); rem1--; end
            k++;
        end
        chk(rem0 == 0 && rem1 == 0, "conflict_done", 32'(rem0 + rem1), 32'd0);
        idle(LAT + 2);

        // Different banks granted together
        op(2'b11, 2'b00, 32'h00, 32'h04, 0, 0, 0, 0, 2'b11, V00, V04, 2'b00, "parallel");
        idle(LAT + 2);

        // Byte strobes, including an all-zero strobe write
        op(2'b01, 2'b01, 32'h20, 0, 32'h1122_3344, 0, 4'hF, 0, 2'b01, 0, 0, 2'b00, "wr20_f");
        op(2'b01, 2'b01, 32'h20, 0, 32'hAABB_CCDD, 0, 4'h5, 0, 2'b01, 0, 0, 2'b00, "wr20_5");
        op(2'b01, 2'b00, 32'h20, 0, 0, 0, 0, 0, 2'b01, 32'h11BB_33DD, 0, 2'b00, "rd20");
        op(2'b10, 2'b10, 0, 32'h20, 0, 32'hFFFF_FFFF, 0, 4'h0, 2'b10, 0, 0, 2'b00, "wr20_0");
        op(2'b10, 2'b00, 0, 32'h20, 0, 0, 0, 0, 2'b10, 0, 32'h11BB_33DD, 2'b00, "rd20_after0");
        idle(LAT + 2);

        // Out of range: bypasses bank 0 arbitration, errors, writes nothing
        op(2'b11, 2'b00, 32'h0004_0000, 32'h00, 0, 0, 0, 0, 2'b11, 0, V00, 2'b01, "oor_rd");
        op(2'b01, 2'b01, 32'h0004_0000, 0, 32'hFFFF_FFFF, 0, 4'hF, 0, 2'b01, 0, 0, 2'b01, "oor_wr");
        op(2'b01, 2'b00, 32'h00, 0, 0, 0, 0, 0, 2'b01, V00, 0, 2'b00, "rd00_after_oor");
        idle(LAT + 3);

        chk(sb_q[0].size() == 0, "drain_p0", 32'(sb_q[0].size()), 32'd0);
        chk(sb_q[1].size() == 0, "drain_p1", 32'(sb_q[1].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
